// File: rtl/demo_song_sequencer.sv
// Note-source controller: picks between live keys and a 16-step demo song,
// and drives the one-hot tone enable plus the 3-bit note code for the display.
module demo_song_sequencer #(
    parameter int TICK_DIV   = 4,
    parameter int NOTE_TICKS = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] keys,
    input  logic       demo_en,
    input  logic       auto_mode,
    input  logic       step,
    output logic [6:0] note_oh,
    output logic [2:0] note_idx,
    output logic [3:0] song_pos,
    output logic       playing,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NOTE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(MAX_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] NOTE_LAST  = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

    // Song ROM: note code for each of the 16 steps.
    function automatic logic [2:0] song_rom(input logic [3:0] pos);
        case (pos)
            4'd0:    song_rom = 3'd3;
            4'd1:    song_rom = 3'd2;
            4'd2:    song_rom = 3'd1;
            4'd3:    song_rom = 3'd2;
            4'd4:    song_rom = 3'd3;
            4'd5:    song_rom = 3'd3;
            4'd6:    song_rom = 3'd3;
            4'd7:    song_rom = 3'd0;
            4'd8:    song_rom = 3'd2;
            4'd9:    song_rom = 3'd2;
            4'd10:   song_rom = 3'd2;
            4'd11:   song_rom = 3'd0;
            4'd12:   song_rom = 3'd3;
            4'd13:   song_rom = 3'd5;
            4'd14:   song_rom = 3'd5;
            default: song_rom = 3'd0;
        endcase
    endfunction

    // Lowest set key wins; later (lower) bits overwrite higher ones.
    function automatic logic [2:0] live_code(input logic [6:0] k);
        live_code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) live_code = 3'(i + 1);
        end
    endfunction

    function automatic logic [6:0] decode_oh(input logic [2:0] code);
        decode_oh = 7'd0;
        if (code != 3'd0) decode_oh[code - 3'd1] = 1'b1;
    endfunction

    // Tick counter saturates at the expiry value so a long manual note cannot wrap it.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v, input logic [TW-1:0] lim);
        sat_inc = (v < lim) ? v + 1'b1 : v;
    endfunction

    logic [1:0]    state, state_n;
    logic [3:0]    pos_n;
    logic [PW-1:0] presc, presc_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          step_q, demo_en_q;
    logic          step_rise, demo_rise, tick, done_n;
    logic [2:0]    idx_n;

    // Next-state, timer and output selection.
    always_comb begin
        step_rise = step & ~step_q;
        demo_rise = demo_en & ~demo_en_q;
        tick      = (presc == PRESC_LAST);
        state_n   = state;
        pos_n     = song_pos;
        presc_n   = tick ? '0 : presc + 1'b1;
        tcnt_n    = tick ? sat_inc(tcnt, (state == S_GAP) ? GAP_LAST : NOTE_LAST) : tcnt;
        done_n    = 1'b0;
        idx_n     = 3'd0;

        case (state)
            S_IDLE: begin
                presc_n = '0;
                tcnt_n  = '0;
                if (demo_rise) begin
                    state_n = S_NOTE;
                    pos_n   = 4'd0;
                end
            end
            S_NOTE: begin
                if (!demo_en) begin
                    state_n = S_IDLE;
                    pos_n   = 4'd0;
                end else if (auto_mode ? (tick && tcnt >= NOTE_LAST) : step_rise) begin
                    state_n = S_GAP;
                    presc_n = '0;
                    tcnt_n  = '0;
                end
            end
            S_GAP: begin
                if (!demo_en) begin
                    state_n = S_IDLE;
                    pos_n   = 4'd0;
                end else if (!auto_mode || (tick && tcnt >= GAP_LAST)) begin
                    presc_n = '0;
                    tcnt_n  = '0;
                    if (song_pos == 4'd15) begin
                        state_n = S_DONE;
                        pos_n   = 4'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_NOTE;
                        pos_n   = song_pos + 4'd1;
                    end
                end
            end
            default: begin
                presc_n = '0;
                tcnt_n  = '0;
                if (!demo_en) begin
                    state_n = S_IDLE;
                    pos_n   = 4'd0;
                end
            end
        endcase

        // Leaving the demo for IDLE gives one silent cycle before keys take over.
        if (state_n == S_IDLE && state == S_IDLE) idx_n = live_code(keys);
        else if (state_n == S_NOTE)               idx_n = song_rom(pos_n);
    end

    // State, timers, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            song_pos  <= 4'd0;
            presc     <= '0;
            tcnt      <= '0;
            step_q    <= 1'b0;
            demo_en_q <= 1'b0;
            note_idx  <= 3'd0;
            note_oh   <= 7'd0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            song_pos  <= pos_n;
            presc     <= presc_n;
            tcnt      <= tcnt_n;
            step_q    <= step;
            demo_en_q <= demo_en;
            note_idx  <= idx_n;
            note_oh   <= decode_oh(idx_n);
            playing   <= (state_n == S_NOTE) || (state_n == S_GAP);
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_demo_song_sequencer.sv
// Directed bench for demo_song_sequencer: live keys, auto song, manual steps,
// demo abort and mid-song reset.
module tb_demo_song_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] keys;
    logic       demo_en, auto_mode, step;
    logic [6:0] note_oh;
    logic [2:0] note_idx;
    logic [3:0] song_pos;
    logic       playing, done;

    int n_vec  = 0;
    int n_miss = 0;

    logic [2:0] song [16] = '{3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0,
                              3'd2, 3'd2, 3'd2, 3'd0, 3'd3, 3'd5, 3'd5, 3'd0};

    demo_song_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .demo_en   (demo_en),
        .auto_mode (auto_mode),
        .step      (step),
        .note_oh   (note_oh),
        .note_idx  (note_idx),
        .song_pos  (song_pos),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] oh_of(input logic [2:0] c);
        logic [6:0] r;
        r = 7'd0;
        if (c != 3'd0) r = 7'd1 << (c - 3'd1);
        return r;
    endfunction

    task automatic chk_note(input string tag, input logic [2:0] exp_idx, input logic [3:0] exp_pos);
        chk_val({tag, "_idx"}, 32'(note_idx), 32'(exp_idx));
        chk_val({tag, "_oh"},  32'(note_oh),  32'(oh_of(exp_idx)));
        chk_val({tag, "_pos"}, 32'(song_pos), 32'(exp_pos));
    endtask

    task automatic manual_pulse();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; keys = 7'd0; demo_en = 1'b0; auto_mode = 1'b1; step = 1'b0;
        cyc();
        cyc();
        chk_note("rst", 3'd0, 4'd0);
        chk_val("rst_playing", 32'(playing), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);

        // Live keys and priority
        rst = 1'b0; keys = 7'b0000100;
        cyc();
        chk_note("live_e", 3'd3, 4'd0);
        keys = 7'b1010010;
        cyc();
        chk_note("live_prio", 3'd2, 4'd0);
        keys = 7'b1000000;
        cyc();
        chk_note("live_b", 3'd7, 4'd0);
        keys = 7'd0;
        cyc();
        chk_note("live_off", 3'd0, 4'd0);

        // Auto song: 16 note cycles, 4 gap cycles per step
        demo_en = 1'b1; auto_mode = 1'b1;
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 20; c++) begin
                cyc();
                chk_note($sformatf("auto_s%0d_c%0d", s, c), (c < 16) ? song[s] : 3'd0, 4'(s));
                chk_val("auto_playing", 32'(playing), 32'd1);
                chk_val("auto_done", 32'(done), 32'd0);
            end
        end
        cyc();
        chk_val("done_pulse", 32'(done), 32'd1);
        chk_val("done_playing", 32'(playing), 32'd0);
        chk_note("done_state", 3'd0, 4'd0);
        cyc();
        chk_val("done_clear", 32'(done), 32'd0);
        chk_val("done_hold", 32'(playing), 32'd0);
        demo_en = 1'b0;
        cyc();
        chk_note("done_exit", 3'd0, 4'd0);

        // Manual stepping
        auto_mode = 1'b0; demo_en = 1'b1;
        cyc();
        chk_note("man_s0", 3'd3, 4'd0);
        repeat (30) cyc();
        chk_note("man_s0_wait", 3'd3, 4'd0);
        step = 1'b1;
        cyc();
        chk_note("man_gap0", 3'd0, 4'd0);
        chk_val("man_gap_playing", 32'(playing), 32'd1);
        cyc();
        chk_note("man_s1", 3'd2, 4'd1);
        repeat (10) cyc();
        chk_note("man_s1_held", 3'd2, 4'd1);
        step = 1'b0;
        cyc();
        chk_note("man_s1_rel", 3'd2, 4'd1);
        step = 1'b1;
        cyc();
        chk_note("man_gap1", 3'd0, 4'd1);
        cyc();
        chk_note("man_s2", 3'd1, 4'd2);
        step = 1'b0;
        cyc();
        repeat (3) manual_pulse();
        chk_note("man_s5", 3'd3, 4'd5);

        // demo_en drop with simultaneous step edge
        step = 1'b1; demo_en = 1'b0; keys = 7'b0001000;
        cyc();
        chk_note("abort", 3'd0, 4'd0);
        chk_val("abort_playing", 32'(playing), 32'd0);
        step = 1'b0;
        cyc();
        chk_note("abort_keys", 3'd4, 4'd0);

        // Reset while in GAP at step 9
        keys = 7'd0; demo_en = 1'b1;
        cyc();
        chk_note("rs_s0", 3'd3, 4'd0);
        repeat (9) manual_pulse();
        chk_note("rs_s9", 3'd2, 4'd9);
        step = 1'b1;
        cyc();
        chk_note("rs_gap9", 3'd0, 4'd9);
        chk_val("rs_gap_playing", 32'(playing), 32'd1);
        rst = 1'b1; demo_en = 1'b0; step = 1'b0;
        cyc();
        chk_note("rs_mid", 3'd0, 4'd0);
        chk_val("rs_mid_playing", 32'(playing), 32'd0);
        chk_val("rs_mid_done", 32'(done), 32'd0);
        rst = 1'b0; keys = 7'b0100000;
        cyc();
        chk_note("rs_idle_keys", 3'd6, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
